// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and sizing helper for the parametrised FIFO
package fifo_pkg;
    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_AF_MARGIN = 2;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: register-array storage, synchronous write port and registered read port
module fifo_mem_2p import fifo_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags,
// read-valid strobe and sticky overflow/underflow flags
module sync_fifo_param import fifo_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int PTR_W   = clog2(DEPTH),
    localparam int CNT_W   = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0] wptr, rptr;
    logic             wr_acc, rd_acc;

    assign empty        = count == '0;
    assign full         = count == FULL_C;
    assign almost_empty = count <= AE_C;
    assign almost_full  = count >= AF_C;
    assign wr_acc       = wr & ~full;
    assign rd_acc       = rd & ~empty;

    fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (dout)
    );

    // Explicit wrap compare keeps non-power-of-two depths correct
    always_ff @(posedge clk)
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            if (rd_acc) rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            count     <= (wr_acc && !rd_acc) ? count + 1'b1 :
                         (rd_acc && !wr_acc) ? count - 1'b1 : count;
            rd_valid  <= rd_acc;
            overflow  <= (wr & full) | (overflow & ~clr_err);
            underflow <= (rd & empty) | (underflow & ~clr_err);
        end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for a 16-deep and a 10-deep FIFO sharing one stimulus bus
module tb_sync_fifo_param;
    logic       clk = 1'b0, rst = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout_a, dout_b;
    logic       rv_a, e_a, f_a, ae_a, af_a, ov_a, un_a;
    logic       rv_b, e_b, f_b, ae_b, af_b, ov_b, un_b;
    logic [4:0] cnt_a;
    logic [3:0] cnt_b;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout_a), .rd_valid(rv_a),
        .empty(e_a), .full(f_a), .almost_empty(ae_a), .almost_full(af_a), .count(cnt_a),
        .clr_err(clr_err), .overflow(ov_a), .underflow(un_a)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(10)) dut_b (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout_b), .rd_valid(rv_b),
        .empty(e_b), .full(f_b), .almost_empty(ae_b), .almost_full(af_b), .count(cnt_b),
        .clr_err(clr_err), .overflow(ov_b), .underflow(un_b)
    );

    typedef struct {
        int rs, w, r, c, d;
        int cnt, dout, v, e, f, ae, af, ov, un;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic c = 1'b0, input logic rs = 1'b0);
        wr = w; rd = r; din = d; clr_err = c; rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        rs w  r  c  din     cnt dout   v  e  f  ae af ov un
        tv[0]  = '{1, 0, 0, 0, 'h00,  0, 'h00, 0, 1, 0, 1, 0, 0, 0};
        tv[1]  = '{0, 0, 1, 0, 'h00,  0, 'h00, 0, 1, 0, 1, 0, 0, 1};
        tv[2]  = '{0, 0, 0, 1, 'h00,  0, 'h00, 0, 1, 0, 1, 0, 0, 0};
        tv[3]  = '{0, 1, 1, 1, 'h11,  1, 'h00, 0, 0, 0, 1, 0, 0, 1};
        tv[4]  = '{0, 1, 0, 0, 'h22,  2, 'h00, 0, 0, 0, 1, 0, 0, 1};
        tv[5]  = '{0, 1, 0, 0, 'h33,  3, 'h00, 0, 0, 0, 0, 0, 0, 1};
        tv[6]  = '{0, 0, 1, 0, 'h00,  2, 'h11, 1, 0, 0, 1, 0, 0, 1};
        tv[7]  = '{0, 1, 1, 0, 'h44,  2, 'h22, 1, 0, 0, 1, 0, 0, 1};
        tv[8]  = '{0, 0, 0, 0, 'h00,  2, 'h22, 0, 0, 0, 1, 0, 0, 1};
        tv[9]  = '{0, 0, 0, 1, 'h00,  2, 'h22, 0, 0, 0, 1, 0, 0, 0};
        tv[10] = '{0, 0, 1, 0, 'h00,  1, 'h33, 1, 0, 0, 1, 0, 0, 0};
        tv[11] = '{0, 0, 1, 0, 'h00,  0, 'h44, 1, 1, 0, 1, 0, 0, 0};
        tv[12] = '{0, 0, 1, 0, 'h00,  0, 'h44, 0, 1, 0, 1, 0, 0, 1};
        tv[13] = '{1, 0, 1, 0, 'h00,  0, 'h00, 0, 1, 0, 1, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            step(tv[i].w[0], tv[i].r[0], tv[i].d[7:0], tv[i].c[0], tv[i].rs[0]);
            chk($sformatf("tv%0d.count", i), 32'(cnt_a), tv[i].cnt);
            chk($sformatf("tv%0d.dout", i), 32'(dout_a), tv[i].dout);
            chk($sformatf("tv%0d.rd_valid", i), 32'(rv_a), tv[i].v);
            chk($sformatf("tv%0d.empty", i), 32'(e_a), tv[i].e);
            chk($sformatf("tv%0d.full", i), 32'(f_a), tv[i].f);
            chk($sformatf("tv%0d.almost_empty", i), 32'(ae_a), tv[i].ae);
            chk($sformatf("tv%0d.almost_full", i), 32'(af_a), tv[i].af);
            chk($sformatf("tv%0d.overflow", i), 32'(ov_a), tv[i].ov);
            chk($sformatf("tv%0d.underflow", i), 32'(un_a), tv[i].un);
        end

        // Fill to full with threshold tracking, overflow while full, then drain
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 8'(i));
            chk("fill.count", 32'(cnt_a), i);
            chk("fill.full", 32'(f_a), 32'(i == 16));
            chk("fill.af", 32'(af_a), 32'(i >= 14));
            chk("fill.ae", 32'(ae_a), 32'(i <= 2));
        end
        step(1, 1, 8'hEE);
        chk("ovf.count", 32'(cnt_a), 15);
        chk("ovf.flag", 32'(ov_a), 1);
        chk("ovf.dout", 32'(dout_a), 8'h01);
        chk("ovf.rd_valid", 32'(rv_a), 1);
        step(0, 0, 0, 1);
        chk("clr.overflow", 32'(ov_a), 0);
        for (int i = 2; i <= 16; i++) begin
            step(0, 1, 0);
            chk("drain.dout", 32'(dout_a), i);
            chk("drain.rd_valid", 32'(rv_a), 1);
            chk("drain.count", 32'(cnt_a), 16 - i);
            chk("drain.ae", 32'(ae_a), 32'(16 - i <= 2));
            chk("drain.af", 32'(af_a), 32'(16 - i >= 14));
        end
        chk("drain.empty", 32'(e_a), 1);
        chk("drain.errs", 32'({ov_a, un_a}), 0);
        step(1, 1, 8'h5A);
        chk("udf.count", 32'(cnt_a), 1);
        chk("udf.flag", 32'(un_a), 1);
        chk("udf.rd_valid", 32'(rv_a), 0);
        chk("udf.dout", 32'(dout_a), 8'h10);
        step(0, 1, 0);
        chk("udf.readback", 32'(dout_a), 8'h5A);

        // Wrap across the pointer boundary on the 16-deep FIFO
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 8'(i + 1));
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            chk("wrap1.dout", 32'(dout_a), i + 1);
        end
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hA0 + i));
        chk("wrap.peak", 32'(cnt_a), 16);
        chk("wrap.full", 32'(f_a), 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0);
            chk("wrap2.dout", 32'(dout_a), 8'hA0 + i);
        end
        chk("wrap.empty", 32'(e_a), 1);

        // Streaming with simultaneous read and write at count 5
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h30 + i));
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 8'(8'h35 + k));
            chk("sim.count", 32'(cnt_a), 5);
            chk("sim.dout", 32'(dout_a), 8'h30 + k);
            chk("sim.rd_valid", 32'(rv_a), 1);
        end

        // Reset mid-stream clears data, dout and errors
        step(0, 0, 0, 0, 1);
        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h60 + i));
        step(0, 1, 0);
        chk("mid.count", 32'(cnt_a), 7);
        chk("mid.dout", 32'(dout_a), 8'h60);
        chk("mid.underflow", 32'(un_a), 1);
        step(1, 1, 8'hFF, 0, 1);
        chk("rst.count", 32'(cnt_a), 0);
        chk("rst.empty", 32'(e_a), 1);
        chk("rst.dout", 32'(dout_a), 0);
        chk("rst.errs", 32'({ov_a, un_a}), 0);
        chk("rst.rd_valid", 32'(rv_a), 0);

        // Non-power-of-two depth: wrap at index 9, full at 10
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 8'(8'h70 + i));
            chk("d10.count", 32'(cnt_b), i + 1);
            chk("d10.full", 32'(f_b), 32'(i == 9));
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            chk("d10.dout1", 32'(dout_b), 8'h70 + i);
        end
        for (int i = 0; i < 10; i++) step(1, 0, 8'(8'hA0 + i));
        chk("d10.full2", 32'(f_b), 1);
        step(1, 0, 8'hEE);
        chk("d10.ovf", 32'(ov_b), 1);
        chk("d10.count_full", 32'(cnt_b), 10);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            chk("d10.dout2", 32'(dout_b), 8'hA0 + i);
        end
        chk("d10.empty", 32'(e_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
